// File: rtl/exec_seq_pkg.sv
// Shared definitions for the execution sequencer: state encoding and parameter defaults.
// The state encoding is also the debug-LED code driven on seq_state.
package exec_seq_pkg;

    typedef enum logic [2:0] {
        ST_BOOT     = 3'd0,
        ST_BIOS_RUN = 3'd1,
        ST_SWAP     = 3'd2,
        ST_USER_RUN = 3'd3,
        ST_WAIT_IN  = 3'd4,
        ST_OUT_WAIT = 3'd5,
        ST_HALTED   = 3'd6
    } seq_state_t;

    localparam int ADDR_W_DEF   = 10;
    localparam int OUT_HOLD_DEF = 4;
    localparam int CNT_W_DEF    = 16;

    // Smallest counter width able to hold OUT_HOLD-1 (at least one bit).
    function automatic int hold_width(input int hold);
        return (hold > 1) ? $clog2(hold) : 1;
    endfunction

endpackage

// File: rtl/seq_hold_timer.sv
// Loadable down-counter for the OUT display-settle stall.
// done is high whenever the count has reached zero; the count parks at zero.
module seq_hold_timer #(
    parameter int W = 2
) (
    input  logic         clock,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/exec_sequencer.sv
// Run-state sequencer for the single-cycle MIPS core: BIOS boot, swap to user memory,
// IN/OUT stalls, single-step and halt. Define SEQ_INSTR_COUNT_EN to build the retired-instruction counter.
//
// state    | meaning
// BOOT     | clear PC after reset, nothing retires
// BIOS_RUN | executing from BIOS
// SWAP     | BIOS halted; clear PC and switch to instruction memory
// USER_RUN | executing from instruction memory
// WAIT_IN  | IN decoded; wait for a button press to latch the switches
// OUT_WAIT | OUT retired; hold so the displays settle
// HALTED   | user HLT; stopped until reset
module exec_sequencer
    import exec_seq_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int OUT_HOLD = OUT_HOLD_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             halt_i,
    input  logic             in_req,
    input  logic             out_req,
    input  logic             btn_pulse,
    input  logic             step_mode,
    output logic             pc_en,
    output logic             pc_clear,
    output logic             change_source,
    output logic             halted,
    output logic [2:0]       seq_state,
    output logic [CNT_W-1:0] instr_count
);

    localparam int HOLD_W = hold_width(OUT_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = (OUT_HOLD > 0) ? HOLD_W'(OUT_HOLD - 1) : '0;
    localparam bit HOLD_EN = (OUT_HOLD > 0);

    if (ADDR_W < 1 || CNT_W < 1 || OUT_HOLD < 0) begin : g_bad_cfg
        $error("exec_sequencer: invalid parameter set");
    end

    seq_state_t state, state_nx;
    logic       ret_user, ret_nx;
    logic       hold_load, hold_done;
    logic       gate;
    seq_state_t ret_target;

    seq_hold_timer #(.W(HOLD_W)) u_hold (
        .clock    (clock),
        .rst      (rst),
        .load     (hold_load),
        .load_val (HOLD_LOAD),
        .done     (hold_done)
    );

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state    <= ST_BOOT;
            ret_user <= 1'b0;
        end else begin
            state    <= state_nx;
            ret_user <= ret_nx;
        end
    end

    assign gate       = step_mode ? btn_pulse : 1'b1;
    assign ret_target = ret_user ? ST_USER_RUN : ST_BIOS_RUN;

    always_comb begin
        state_nx  = state;
        ret_nx    = ret_user;
        pc_en     = 1'b0;
        hold_load = 1'b0;
        case (state)
            ST_BOOT: state_nx = ST_BIOS_RUN;
            ST_BIOS_RUN, ST_USER_RUN: begin
                if (halt_i) begin
                    state_nx = (state == ST_USER_RUN) ? ST_HALTED : ST_SWAP;
                end else if (in_req) begin
                    // A button press in the decode cycle is deliberately dropped.
                    state_nx = ST_WAIT_IN;
                    ret_nx   = (state == ST_USER_RUN);
                end else begin
                    pc_en = gate;
                    if (out_req && gate && HOLD_EN) begin
                        state_nx  = ST_OUT_WAIT;
                        ret_nx    = (state == ST_USER_RUN);
                        hold_load = 1'b1;
                    end
                end
            end
            ST_SWAP: state_nx = ST_USER_RUN;
            ST_WAIT_IN: begin
                if (btn_pulse) begin
                    pc_en    = 1'b1;
                    state_nx = ret_target;
                end
            end
            ST_OUT_WAIT: begin
                if (hold_done) begin
                    state_nx = ret_target;
                end
            end
            ST_HALTED: state_nx = ST_HALTED;
            default:   state_nx = ST_BOOT;
        endcase
    end

    assign pc_clear      = (state == ST_BOOT) || (state == ST_SWAP);
    assign halted        = (state == ST_HALTED);
    assign seq_state     = state;
    assign change_source = (state == ST_USER_RUN) || (state == ST_HALTED) ||
                           (((state == ST_WAIT_IN) || (state == ST_OUT_WAIT)) && ret_user);

`ifdef SEQ_INSTR_COUNT_EN
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            instr_count <= '0;
        end else if (pc_en) begin
            instr_count <= instr_count + 1'b1;
        end
    end
`else
    assign instr_count = '0;
`endif

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed self-checking bench for exec_sequencer (OUT_HOLD=4, CNT_W=16).
// Expected instruction counts follow SEQ_INSTR_COUNT_EN; without it the count must stay 0.
module tb_exec_sequencer;

    logic        clock = 1'b0;
    logic        rst;
    logic        halt_i, in_req, out_req, btn_pulse, step_mode;
    logic        pc_en, pc_clear, change_source, halted;
    logic [2:0]  seq_state;
    logic [15:0] instr_count;

    int n_cmp = 0;
    int n_bad = 0;
    int n_ret = 0;

    exec_sequencer #(.ADDR_W(10), .OUT_HOLD(4), .CNT_W(16)) dut (
        .clock         (clock),
        .rst           (rst),
        .halt_i        (halt_i),
        .in_req        (in_req),
        .out_req       (out_req),
        .btn_pulse     (btn_pulse),
        .step_mode     (step_mode),
        .pc_en         (pc_en),
        .pc_clear      (pc_clear),
        .change_source (change_source),
        .halted        (halted),
        .seq_state     (seq_state),
        .instr_count   (instr_count)
    );

    always #5 clock = ~clock;

    function automatic int exp_cnt(input int n);
`ifdef SEQ_INSTR_COUNT_EN
        return n & 16'hFFFF;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    // Expected instruction count is kept as n_ret and bumped by hand after each expected retire.
    task automatic chk_cnt(input string tag);
        chk(tag, int'(instr_count), exp_cnt(n_ret));
    endtask

    initial begin
        rst = 1'b0; halt_i = 1'b0; in_req = 1'b0; out_req = 1'b0;
        btn_pulse = 1'b0; step_mode = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_state", int'(seq_state), 0);
        chk("rst_pc_clear", int'(pc_clear), 1);
        chk("rst_pc_en", int'(pc_en), 0);
        chk("rst_src", int'(change_source), 0);
        chk("rst_halted", int'(halted), 0);
        chk("rst_cnt", int'(instr_count), 0);

        // Cycle 1 after release: BOOT.
        rst = 1'b1; #1;
        chk("boot_state", int'(seq_state), 0);
        chk("boot_pc_clear", int'(pc_clear), 1);
        chk("boot_pc_en", int'(pc_en), 0);

        // Cycle 2: first BIOS retire.
        next_cycle();
        chk("bios_state", int'(seq_state), 1);
        chk("bios_pc_en", int'(pc_en), 1);
        chk("bios_pc_clear", int'(pc_clear), 0);
        chk("bios_src", int'(change_source), 0);
        chk_cnt("bios_cnt0");
        n_ret++;
        next_cycle(); chk_cnt("bios_cnt1"); chk("bios_pc_en1", int'(pc_en), 1); n_ret++;
        next_cycle(); chk_cnt("bios_cnt2"); chk("bios_pc_en2", int'(pc_en), 1); n_ret++;

        // BIOS HLT: no retire, SWAP, then user memory.
        next_cycle();
        halt_i = 1'b1; #1;
        chk("bhlt_pc_en", int'(pc_en), 0);
        next_cycle();
        halt_i = 1'b0; #1;
        chk("swap_state", int'(seq_state), 2);
        chk("swap_pc_clear", int'(pc_clear), 1);
        chk("swap_pc_en", int'(pc_en), 0);
        chk_cnt("swap_cnt");
        next_cycle();
        chk("user_state", int'(seq_state), 3);
        chk("user_src", int'(change_source), 1);
        chk("user_pc_en", int'(pc_en), 1);
        chk("user_pc_clear", int'(pc_clear), 0);
        n_ret++;

        // IN in USER_RUN with a same-cycle press that must be ignored.
        next_cycle();
        in_req = 1'b1; btn_pulse = 1'b1; #1;
        chk("in_dec_pc_en", int'(pc_en), 0);
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            btn_pulse = 1'b0; #1;
            chk("in_wait_state", int'(seq_state), 4);
            chk("in_wait_pc_en", int'(pc_en), 0);
            chk("in_wait_src", int'(change_source), 1);
        end
        next_cycle();
        btn_pulse = 1'b1; #1;
        chk("in_btn_pc_en", int'(pc_en), 1);
        n_ret++;
        next_cycle();
        btn_pulse = 1'b0; in_req = 1'b0; #1;
        chk("in_ret_state", int'(seq_state), 3);
        chk("in_ret_pc_en", int'(pc_en), 1);
        chk_cnt("in_cnt");
        n_ret++;

        // OUT with a 4-cycle hold.
        next_cycle();
        out_req = 1'b1; #1;
        chk("out_pc_en", int'(pc_en), 1);
        n_ret++;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            out_req = 1'b0; #1;
            chk("out_hold_state", int'(seq_state), 5);
            chk("out_hold_pc_en", int'(pc_en), 0);
            chk("out_hold_src", int'(change_source), 1);
        end
        next_cycle();
        chk("out_ret_state", int'(seq_state), 3);
        chk("out_ret_pc_en", int'(pc_en), 1);
        chk_cnt("out_cnt");
        n_ret++;

        // Single-step: three presses spaced 3 cycles apart.
        next_cycle();
        step_mode = 1'b1; #1;
        chk("step_idle_pc_en", int'(pc_en), 0);
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            btn_pulse = 1'b0; #1;
            chk("step_gap_pc_en", int'(pc_en), 0);
            next_cycle();
            chk("step_gap_pc_en", int'(pc_en), 0);
            next_cycle();
            btn_pulse = 1'b1; #1;
            chk("step_btn_pc_en", int'(pc_en), 1);
            n_ret++;
        end
        next_cycle();
        btn_pulse = 1'b0; #1;
        chk_cnt("step_cnt");

        // HLT together with a press in USER_RUN: no retire, HALTED.
        next_cycle();
        halt_i = 1'b1; btn_pulse = 1'b1; #1;
        chk("uhlt_pc_en", int'(pc_en), 0);
        next_cycle();
        halt_i = 1'b0; step_mode = 1'b0; in_req = 1'b1; #1;
        chk("halt_state", int'(seq_state), 6);
        chk("halt_halted", int'(halted), 1);
        chk("halt_src", int'(change_source), 1);
        chk("halt_pc_en", int'(pc_en), 0);
        next_cycle();
        in_req = 1'b0; out_req = 1'b1; #1;
        chk("halt_stay_state", int'(seq_state), 6);
        chk("halt_stay_pc_en", int'(pc_en), 0);
        chk_cnt("halt_cnt");

        // Asynchronous reset while HALTED, away from any clock edge.
        #1; rst = 1'b0; out_req = 1'b0; btn_pulse = 1'b0; #1;
        chk("arst_h_state", int'(seq_state), 0);
        chk("arst_h_halted", int'(halted), 0);
        chk("arst_h_pc_clear", int'(pc_clear), 1);
        chk("arst_h_src", int'(change_source), 0);
        chk("arst_h_cnt", int'(instr_count), 0);
        n_ret = 0;

        // Restart, IN from BIOS returns to BIOS, then reset inside WAIT_IN.
        next_cycle();
        rst = 1'b1; #1;
        chk("boot2_state", int'(seq_state), 0);
        next_cycle();
        in_req = 1'b1; #1;
        chk("bin_pc_en", int'(pc_en), 0);
        next_cycle();
        chk("bin_wait_state", int'(seq_state), 4);
        chk("bin_wait_src", int'(change_source), 0);
        btn_pulse = 1'b1; #1;
        chk("bin_btn_pc_en", int'(pc_en), 1);
        next_cycle();
        btn_pulse = 1'b0; #1;
        chk("bin_ret_state", int'(seq_state), 1);
        chk("bin_ret_src", int'(change_source), 0);
        chk("bin_ret_cnt", int'(instr_count), exp_cnt(1));
        next_cycle();
        chk("bin2_wait_state", int'(seq_state), 4);
        #1; rst = 1'b0; #1;
        chk("arst_w_state", int'(seq_state), 0);
        chk("arst_w_pc_en", int'(pc_en), 0);
        chk("arst_w_pc_clear", int'(pc_clear), 1);
        chk("arst_w_cnt", int'(instr_count), 0);
        in_req = 1'b0;
        next_cycle();
        chk("arst_w_hold_state", int'(seq_state), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/exec_sequencer.md
# exec_sequencer

Execution sequencer for the single-cycle MIPS core. It owns the run state of the processor: boot from BIOS, hand-over to instruction memory on the BIOS halt, stalls for IN and OUT instructions, single-step mode and final halt. It drives the PC/architectural write enable, the PC clear and the BIOS/instruction-memory source select, replacing ad-hoc halt and source logic in the PC.

## Interface
Parameters:
- ADDR_W, 10, PC width; informational, passed to the package for consistency checks.
- OUT_HOLD, 4, stall cycles after an OUT instruction so the displays settle; 0 disables the hold.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clock  in  1  system clock (divided clock from the temporizer).
- rst  in  1  asynchronous, active-low reset.
- halt_i  in  1  current instruction is HLT (decoded by control unit).
- in_req  in  1  current instruction is IN (reads switches).
- out_req  in  1  current instruction is OUT.
- btn_pulse  in  1  one-cycle debounced button pulse, synchronous to clock.
- step_mode  in  1  1 = one instruction per btn_pulse.
- pc_en  out  1  PC update and all architectural writes (regbank, data memory, output module) allowed this cycle.
- pc_clear  out  1  force PC to 0 at next edge.
- change_source  out  1  0 = BIOS, 1 = instruction memory.
- halted  out  1  processor stopped until reset.
- seq_state  out  3  encoded FSM state, for debug LEDs.
- instr_count  out  CNT_W  retired-instruction count.

## Operation
- States: BOOT, BIOS_RUN, SWAP, USER_RUN, WAIT_IN, OUT_WAIT, HALTED.
- Internal: ret_user bit (the run state to return to), hold_cnt.
- BOOT: pc_clear=1, pc_en=0; next BIOS_RUN.
- BIOS_RUN / USER_RUN (run states), priority order:
  - halt_i: pc_en=0; BIOS_RUN→SWAP, USER_RUN→HALTED.
  - in_req: pc_en=0; →WAIT_IN, ret_user set from current state. A btn_pulse in the same cycle is ignored; a fresh press is required.
  - out_req: pc_en=gate; if gate=1 and OUT_HOLD>0, →OUT_WAIT and load hold_cnt=OUT_HOLD-1.
  - otherwise pc_en=gate, where gate = step_mode ? btn_pulse : 1.
- SWAP: pc_clear=1, pc_en=0; next USER_RUN.
- WAIT_IN: pc_en=0 until btn_pulse; on btn_pulse, pc_en=1 (instruction retires with the switch value), then return to BIOS_RUN or USER_RUN per ret_user.
- OUT_WAIT: pc_en=0; hold_cnt decrements each cycle; at 0, return per ret_user.
- HALTED: pc_en=0, halted=1. All inputs are ignored; only reset exits.
- change_source=1 in USER_RUN, HALTED, and in WAIT_IN/OUT_WAIT when ret_user=1; otherwise 0.
- instr_count increments on every cycle with pc_en=1 and wraps modulo 2^CNT_W.

## Timing
- State, ret_user, hold_cnt and instr_count are registered.
- pc_en is Mealy: combinational from state, halt_i, in_req, btn_pulse and step_mode, so a HLT or IN never retires in the cycle it is decoded.
- pc_clear, change_source, halted and seq_state are Moore, decoded from state only.
- Reset values (rst low, asynchronous): state=BOOT, pc_clear=1, pc_en=0, change_source=0, halted=0, ret_user=0, hold_cnt=0, instr_count=0.
- Reset asserted mid-operation aborts any state immediately, including WAIT_IN, OUT_WAIT and HALTED.
- Latency:
  - Reset release → first BIOS instruction retires in cycle 2 (BOOT takes one cycle).
  - BIOS halt → first user instruction at address 0 retires 2 cycles later (SWAP takes one cycle).
- OUT stall: OUT_HOLD cycles with pc_en=0 after the OUT retires.

## Configuration
- SEQ_INSTR_COUNT_EN defined: instr_count is implemented as specified.
- Not defined: the counter register is removed and instr_count is tied to 0. All other behaviour is identical.

## Structure
- Shared package exec_seq_pkg holds:
  - the state enum with its 3-bit encoding (BOOT=0, BIOS_RUN=1, SWAP=2, USER_RUN=3, WAIT_IN=4, OUT_WAIT=5, HALTED=6);
  - default values for OUT_HOLD and CNT_W.
- One sub-module, seq_hold_timer: loadable down-counter with a done flag, used for OUT_WAIT.

## Test plan
- Reset release, step_mode=0, no requests → cycle 1 pc_clear=1 and pc_en=0; from cycle 2 pc_en=1, change_source=0, instr_count increments by 1 per cycle.
- halt_i for 1 cycle in BIOS_RUN → pc_en=0 that cycle; next cycle SWAP with pc_clear=1; then USER_RUN with change_source=1 and pc_en=1.
- in_req held in USER_RUN, btn_pulse at +5 cycles → pc_en=0 for 5 cycles, pc_en=1 exactly in the pulse cycle, then USER_RUN; instr_count rises by exactly 1 over the stall.
- out_req with OUT_HOLD=4 → pc_en=1 in the OUT cycle, then 4 cycles pc_en=0, then pc_en=1.
- step_mode=1, three btn_pulses spaced 3 cycles apart → exactly three pc_en=1 cycles; a simultaneous halt_i+btn_pulse in USER_RUN → HALTED with no retire.
- rst low during WAIT_IN or HALTED → asynchronously BOOT with reset values; with SEQ_INSTR_COUNT_EN undefined, instr_count=0 throughout.
